tone_sequencer: RTL and testbench



---
 rtl/tone_sequencer.sv | 128 ++++++++++++
 tb/tb_tone_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// tone_sequencer: walks a song held in an external synchronous ROM and holds
// each note for a programmable number of clocks. It drives the frequency word
// and output enable of tone_generator, with start/pause control and live tempo.
// Optional build macro SEQ_LOOP_EN: when defined, the end marker restarts the
// song from address 0 instead of returning to idle.
module tone_sequencer #(
  parameter int ADDR_W              = 9,
  parameter int TONE_W              = 24,
  parameter int NOTE_CYCLES_DEFAULT = 12500000,
  parameter int TEMPO_STEP          = 1250000,
  parameter int NOTE_CYCLES_MIN     = 1250000,
  parameter int NOTE_CYCLES_MAX     = 62500000,
  parameter int CNT_W               = 27
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_tempo_up,
  input  logic              i_tempo_down,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [TONE_W-1:0] i_rom_data,
  output logic [TONE_W-1:0] o_tone_out,
  output logic              o_tone_en,
  output logic              o_playing,
  output logic              o_done
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LATCH, S_PLAY, S_PAUSED} state_t;

  localparam logic [TONE_W-1:0] END_MARK = '1;
  localparam logic [CNT_W-1:0]  C_DEF    = CNT_W'(NOTE_CYCLES_DEFAULT);
  localparam logic [CNT_W-1:0]  C_STEP   = CNT_W'(TEMPO_STEP);
  localparam logic [CNT_W-1:0]  C_MIN    = CNT_W'(NOTE_CYCLES_MIN);
  localparam logic [CNT_W-1:0]  C_MAX    = CNT_W'(NOTE_CYCLES_MAX);
  localparam logic [CNT_W-1:0]  C_ONE    = CNT_W'(1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_note_cycles;
  logic [CNT_W-1:0]   r_note_cnt;
  logic               w_note_last;
  logic               w_end;

  // >= rather than == so a tempo change that shortens the note below the
  // current count still ends it on the next cycle.
  assign w_note_last = (r_note_cnt >= (r_note_cycles - C_ONE));
  assign w_end       = (i_rom_data == END_MARK);

  // Note length register: clamped tempo adjust, simultaneous pulses cancel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_note_cycles <= C_DEF;
    end else if (i_tempo_up && !i_tempo_down) begin
      r_note_cycles <= (r_note_cycles < (C_MIN + C_STEP)) ? C_MIN : (r_note_cycles - C_STEP);
    end else if (i_tempo_down && !i_tempo_up) begin
      r_note_cycles <= (r_note_cycles > (C_MAX - C_STEP)) ? C_MAX : (r_note_cycles + C_STEP);
    end
  end

  // Sequencer FSM with registered outputs; start overrides everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_note_cnt <= '0;
      o_rom_addr <= '0;
      o_tone_out <= '0;
      o_tone_en  <= 1'b0;
      o_playing  <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        // Tone outputs hold until the first note is latched.
        o_rom_addr <= '0;
        o_playing  <= 1'b1;
        r_state    <= S_WAIT;
      end else begin
        case (r_state)
          S_IDLE: ;
          // ROM is sampling o_rom_addr this cycle.
          S_WAIT: r_state <= S_LATCH;
          S_LATCH: begin
            if (w_end) begin
              o_done <= 1'b1;
`ifdef SEQ_LOOP_EN
              o_rom_addr <= '0;
              r_state    <= S_WAIT;
`else
              o_tone_out <= '0;
              o_tone_en  <= 1'b0;
              o_playing  <= 1'b0;
              r_state    <= S_IDLE;
`endif
            end else begin
              // A zero word is a rest: enabled with frequency 0.
              o_tone_out <= i_rom_data;
              o_tone_en  <= 1'b1;
              r_note_cnt <= '0;
              r_state    <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (i_pause) begin
              o_tone_en <= 1'b0;
              o_playing <= 1'b0;
              r_state   <= S_PAUSED;
            end else if (w_note_last) begin
              o_rom_addr <= o_rom_addr + ADDR_W'(1);
              r_state    <= S_WAIT;
            end else begin
              r_note_cnt <= r_note_cnt + C_ONE;
            end
          end
          S_PAUSED: begin
            // Count stays frozen so the note resumes where it stopped.
            if (i_pause) begin
              o_tone_en <= 1'b1;
              o_playing <= 1'b1;
              r_state   <= S_PLAY;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: cycle-level reference model plus directed timing
// checks on note lengths, pause, tempo, restart and reset.
module tb_tone_sequencer;
  localparam int DEF = 10, STEP = 2, MINL = 4, MAXL = 20;
  localparam logic [23:0] ENDW = 24'hFFFFFF;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, pause = 1'b0, tempo_up = 1'b0, tempo_down = 1'b0;
  logic [2:0]  o_rom_addr;
  logic [23:0] rom_data;
  logic [23:0] o_tone_out;
  logic        o_tone_en, o_playing, o_done;
  logic [23:0] rom [8];

  int errs = 0, checks = 0, cyc = 0;
  int dn_cnt = 0, dn_t = 0, dn_gap = 0;

  tone_sequencer #(
    .ADDR_W(3), .TONE_W(24), .NOTE_CYCLES_DEFAULT(DEF), .TEMPO_STEP(STEP),
    .NOTE_CYCLES_MIN(MINL), .NOTE_CYCLES_MAX(MAXL), .CNT_W(27)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause),
    .i_tempo_up(tempo_up), .i_tempo_down(tempo_down),
    .o_rom_addr(o_rom_addr), .i_rom_data(rom_data),
    .o_tone_out(o_tone_out), .o_tone_en(o_tone_en),
    .o_playing(o_playing), .o_done(o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // 1-cycle-latency synchronous ROM
  always @(posedge clk) rom_data <= rom[o_rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: song position, fetch countdown, cycles played in note.
  bit          m_busy, m_paused, m_en, m_done;
  int          m_fetch, m_el, m_addr, m_len;
  logic [23:0] m_tone;
  always @(posedge clk or posedge rst) begin
    int nlen;
    logic [23:0] w;
    if (rst) begin
      m_busy = 0; m_paused = 0; m_en = 0; m_done = 0;
      m_fetch = 0; m_el = 0; m_addr = 0; m_len = DEF; m_tone = '0;
    end else begin
      nlen = m_len;
      if (tempo_up && !tempo_down)      nlen = (m_len - STEP < MINL) ? MINL : m_len - STEP;
      else if (tempo_down && !tempo_up) nlen = (m_len + STEP > MAXL) ? MAXL : m_len + STEP;
      m_done = 0;
      if (start) begin
        m_busy = 1; m_paused = 0; m_fetch = 2; m_addr = 0;
      end else if (m_busy) begin
        if (m_fetch == 2) m_fetch = 1;
        else if (m_fetch == 1) begin
          w = rom[m_addr];
          if (w == ENDW) begin
            m_done = 1;
`ifdef SEQ_LOOP_EN
            m_addr = 0; m_fetch = 2;
`else
            m_busy = 0; m_fetch = 0; m_tone = '0; m_en = 0;
`endif
          end else begin
            m_tone = w; m_en = 1; m_el = 0; m_fetch = 0;
          end
        end else if (m_paused) begin
          if (pause) begin m_paused = 0; m_en = 1; end
        end else if (pause) begin
          m_paused = 1; m_en = 0;
        end else if (m_el + 1 >= m_len) begin
          m_addr = (m_addr + 1) % 8; m_fetch = 2;
        end else begin
          m_el++;
        end
      end
      m_len = nlen;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("tone_out", 32'(o_tone_out), 32'(m_tone));
    chk("tone_en",  32'(o_tone_en),  32'(m_en));
    chk("playing",  32'(o_playing),  32'(m_busy && !m_paused));
    chk("done",     32'(o_done),     32'(m_done));
    chk("rom_addr", 32'(o_rom_addr), 32'(m_addr));
  end

  // done pulse monitor: count and spacing
  always @(negedge clk) if (o_done) begin
    dn_cnt++; dn_gap = cyc - dn_t; dn_t = cyc;
  end

  task automatic wait_tone(input logic [23:0] tv, input logic te, input string nm, output int t);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(o_tone_out == tv && o_tone_en == te) && n < 400);
    if (!(o_tone_out == tv && o_tone_en == te)) chk({"timeout_", nm}, 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic set_song(input logic [23:0] a, b, c, d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    for (int i = 4; i < 8; i++) rom[i] = ENDW;
  endtask

  initial begin
    int t0, t1, t2, t3, r;
    for (int i = 0; i < 8; i++) rom[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tone_out", 32'(o_tone_out), 0);
    chk("rst_tone_en",  32'(o_tone_en), 0);
    chk("rst_playing",  32'(o_playing), 0);
    chk("rst_rom_addr", 32'(o_rom_addr), 0);

`ifndef SEQ_LOOP_EN
    // Basic song: 12 clocks per note, one done pulse, idle at address 3.
    set_song(24'd500, 24'd0, 24'd220, ENDW);
    dn_cnt = 0;
    pulse_start();
    wait_tone(24'd500, 1'b1, "t1_500", t0);
    wait_tone(24'd0,   1'b1, "t1_rest", t1);
    wait_tone(24'd220, 1'b1, "t1_220", t2);
    wait_tone(24'd0,   1'b0, "t1_end", t3);
    chk("t1_len500",  32'(t1 - t0), 12);
    chk("t1_lenrest", 32'(t2 - t1), 12);
    chk("t1_len220",  32'(t3 - t2), 12);
    chk("t1_done",    32'(o_done), 1);
    chk("t1_addr",    32'(o_rom_addr), 3);
    chk("t1_playing", 32'(o_playing), 0);
    repeat (5) @(negedge clk);
    chk("t1_done_cnt", 32'(dn_cnt), 1);

    // Pause 5 cycles into the note for 20 cycles.
    do_reset();
    set_song(24'd500, 24'd220, ENDW, ENDW);
    pulse_start();
    wait_tone(24'd500, 1'b1, "t2_500", t0);
    repeat (5) @(posedge clk);
    #1 pause = 1'b1;
    @(posedge clk); #1 pause = 1'b0;
    wait_tone(24'd500, 1'b0, "t2_paused", t1);
    repeat (19) @(posedge clk);
    #1 pause = 1'b1;
    @(posedge clk); #1 pause = 1'b0;
    wait_tone(24'd500, 1'b1, "t2_resume", t2);
    chk("t2_pause_len", 32'(t2 - t1), 20);
    wait_tone(24'd220, 1'b1, "t2_next", t3);
    chk("t2_remain", 32'(t3 - t2), 7);

    // Tempo clamps, measured as note duration (length + 2).
    do_reset();
    @(posedge clk); #1 tempo_up = 1'b1;
    repeat (4) @(posedge clk);
    #1 tempo_up = 1'b0;
    pulse_start();
    wait_tone(24'd500, 1'b1, "t3a_500", t0);
    wait_tone(24'd220, 1'b1, "t3a_220", t1);
    chk("t3_min_len", 32'(t1 - t0), 6);
    wait_tone(24'd0, 1'b0, "t3a_end", t3);
    @(posedge clk); #1 tempo_down = 1'b1;
    repeat (10) @(posedge clk);
    #1 tempo_down = 1'b0;
    pulse_start();
    wait_tone(24'd500, 1'b1, "t3b_500", t0);
    wait_tone(24'd220, 1'b1, "t3b_220", t1);
    chk("t3_max_len", 32'(t1 - t0), 22);
    wait_tone(24'd0, 1'b0, "t3b_end", t3);
    @(posedge clk); #1 tempo_up = 1'b1; tempo_down = 1'b1;
    repeat (3) @(posedge clk);
    #1 tempo_up = 1'b0; tempo_down = 1'b0;
    pulse_start();
    wait_tone(24'd500, 1'b1, "t3c_500", t0);
    wait_tone(24'd220, 1'b1, "t3c_220", t1);
    chk("t3_both_len", 32'(t1 - t0), 22);
    wait_tone(24'd0, 1'b0, "t3c_end", t3);

    // Mid-note shortening below the current count ends the note at once.
    do_reset();
    pulse_start();
    wait_tone(24'd500, 1'b1, "t4_500", t0);
    @(posedge clk); #1 tempo_up = 1'b1;
    repeat (3) @(posedge clk);
    #1 tempo_up = 1'b0;
    wait_tone(24'd220, 1'b1, "t4_220", t1);
    chk("t4_short_len", 32'(t1 - t0), 7);
    chk("t4_addr", 32'(o_rom_addr), 1);
`endif

    // Restart while at address 2, then asynchronous reset mid-note.
    do_reset();
    set_song(24'd500, 24'd0, 24'd220, ENDW);
    pulse_start();
    wait_tone(24'd220, 1'b1, "t5_220", t0);
    chk("t5_addr2", 32'(o_rom_addr), 2);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t1 = cyc;
    chk("t5_addr0", 32'(o_rom_addr), 0);
    chk("t5_hold", 32'(o_tone_out), 220);
    wait_tone(24'd500, 1'b1, "t5_relatch", t2);
    chk("t5_relatch_lat", 32'(t2 - t1), 2);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_en",   32'(o_tone_en), 0);
    chk("t5_async_tone", 32'(o_tone_out), 0);
    chk("t5_async_play", 32'(o_playing), 0);
    @(posedge clk); #1 rst = 1'b0;

`ifdef SEQ_LOOP_EN
    // Continuous loop of {500, end}: done every 14 clocks, tone held.
    set_song(24'd500, ENDW, ENDW, ENDW);
    dn_cnt = 0;
    pulse_start();
    repeat (60) @(negedge clk);
    chk("t6_done_cnt_ge3", 32'(dn_cnt >= 3), 1);
    chk("t6_done_gap", 32'(dn_gap), 14);
    chk("t6_tone_held", 32'(o_tone_out), 500);
    chk("t6_en_held", 32'(o_tone_en), 1);
    // No marker: wraps 7 -> 0.
    do_reset();
    for (int i = 0; i < 8; i++) rom[i] = 24'(100 + i);
    pulse_start();
    wait_tone(24'd107, 1'b1, "t6_last", t0);
    wait_tone(24'd100, 1'b1, "t6_wrap", t1);
    chk("t6_wrap_addr", 32'(o_rom_addr), 0);
`endif

    // Randomized run checked by the model.
    do_reset();
    for (int a = 0; a < 8; a++) begin
      r = int'($urandom_range(0, 9));
      rom[a] = (r == 0) ? ENDW : (r == 1) ? 24'd0 : 24'($urandom_range(1, 32'hFFFFFE));
    end
    pulse_start();
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start      = ($urandom_range(0, 149) == 0);
      pause      = ($urandom_range(0, 29) == 0);
      tempo_up   = ($urandom_range(0, 24) == 0);
      tempo_down = ($urandom_range(0, 24) == 0);
      rst        = ($urandom_range(0, 1499) == 0);
    end
    @(posedge clk); #1;
    start = 0; pause = 0; tempo_up = 0; tempo_down = 0; rst = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
